// File: rtl/hist_eq_pkg.sv
// Shared constants, FSM state type and pixel-extraction helper for the
// histogram-equalizer output path (M4 readout streamer).
package hist_eq_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 128;
  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = DATA_W / PIX_W;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } readout_state_t;

  // Byte idx of an M4 word; byte 0 lives in bits [PIX_W-1:0].
  function automatic logic [PIX_W-1:0] pixel_of(input logic [DATA_W-1:0] word,
                                                input logic [IDX_W-1:0]  idx);
    logic [DATA_W-1:0] shifted;
    shifted = word >> (idx * PIX_W);
    return shifted[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/m4_readout_streamer_if.sv
// M4 read port plus outgoing pixel valid/ready stream.
// master = streamer side, slave = memory/sink side.
interface m4_readout_streamer_if;
  import hist_eq_pkg::*;

  logic [ADDR_W-1:0] M4_ReadAddress;
  logic [DATA_W-1:0] M4_ReadBus;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output M4_ReadAddress,
    input  M4_ReadBus,
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  M4_ReadAddress,
    output M4_ReadBus,
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/m4_readout_streamer_word_fifo2.sv
// word_fifo2: two-entry DATA_W word FIFO. Simultaneous push and pop leaves
// occupancy unchanged; push when full and pop when empty are ignored.
module word_fifo2 import hist_eq_pkg::*; (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [1:0]        o_count,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push && (r_count != 2'd2);
  assign w_pop   = i_pop  && (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/m4_readout_streamer.sv
// m4_readout_streamer: fetches word_count M4 words starting at base_addr and
// streams them out byte 0 first as PIX_W-bit pixels over valid/ready.
// Optional feature macro: M4_READOUT_CHECKSUM_EN (16-bit pixel sum on checksum).
module m4_readout_streamer import hist_eq_pkg::*; (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum,
  m4_readout_streamer_if.master bus
);

  readout_state_t    r_state;
  readout_state_t    w_state_next;
  logic [ADDR_W-1:0] r_read_addr;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_words_left;
  logic              r_inflight;    // address phase of the outstanding read
  logic              r_data_phase;  // M4_ReadBus carries the read data
  logic [IDX_W-1:0]  r_idx;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [1:0]        w_fifo_count;
  logic [DATA_W-1:0] w_head;
  logic              w_start_ok;
  logic              w_launch;
  logic              w_read_busy;
  logic              w_issue;
  logic              w_pix_valid;
  logic              w_hs;
  logic              w_pop;
  logic              w_last;

  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_launch    = w_start_ok && (word_count != {ADDR_W{1'b0}});
  assign w_read_busy = r_inflight | r_data_phase;
  // Only one read outstanding, and never more words than the FIFO can hold.
  assign w_issue     = (r_state == RUN) && (r_words_left != {ADDR_W{1'b0}}) &&
                       !w_read_busy && !w_fifo_full;
  assign w_pix_valid = !w_fifo_empty;
  assign w_hs        = w_pix_valid && bus.pix_ready;
  assign w_pop       = w_hs && (r_idx == IDX_W'(PIX_PER_WORD - 1));
  // Final pop: nothing left to issue, nothing outstanding, only the head queued.
  assign w_last      = w_pop && (w_fifo_count == 2'd1) &&
                       (r_words_left == {ADDR_W{1'b0}}) && !w_read_busy;

  assign bus.pix_valid      = w_pix_valid;
  assign bus.pix_data       = w_pix_valid ? pixel_of(w_head, r_idx) : {PIX_W{1'b0}};
  assign bus.M4_ReadAddress = r_read_addr;
  assign busy               = (r_state == RUN);
  assign done               = (r_state == DONE);

  word_fifo2 u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_data_phase),
    .i_pop   (w_pop),
    .i_data  (bus.M4_ReadBus),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          if (word_count != {ADDR_W{1'b0}}) w_state_next = RUN;
          else                              w_state_next = DONE;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
        else        w_state_next = RUN;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Read issue: first read launches straight from IDLE on start, the rest
  // are issued from RUN; addresses wrap modulo 2^ADDR_W.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_addr  <= {ADDR_W{1'b0}};
      r_next_addr  <= {ADDR_W{1'b0}};
      r_words_left <= {ADDR_W{1'b0}};
      r_inflight   <= 1'b0;
      r_data_phase <= 1'b0;
    end else begin
      r_data_phase <= r_inflight;
      if (w_launch) begin
        r_read_addr  <= base_addr;
        r_next_addr  <= base_addr + ADDR_W'(1);
        r_words_left <= word_count - ADDR_W'(1);
        r_inflight   <= 1'b1;
      end else if (w_issue) begin
        r_read_addr  <= r_next_addr;
        r_next_addr  <= r_next_addr + ADDR_W'(1);
        r_words_left <= r_words_left - ADDR_W'(1);
        r_inflight   <= 1'b1;
      end else begin
        r_inflight   <= 1'b0;
      end
    end
  end

  // Serializer byte index; wraps to 0 when the head word is popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (w_hs) begin
      if (w_pop) r_idx <= {IDX_W{1'b0}};
      else       r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

`ifdef M4_READOUT_CHECKSUM_EN
  logic [15:0] r_csum;

  // Pixel sum: cleared on accepted start, accumulates every handshaken pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_csum <= 16'h0000;
    end else if (w_start_ok) begin
      r_csum <= 16'h0000;
    end else if (w_hs) begin
      r_csum <= r_csum + {{(16-PIX_W){1'b0}}, bus.pix_data};
    end else begin
      r_csum <= r_csum;
    end
  end

  assign checksum = r_csum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: doc/m4_readout_streamer.md
# m4_readout_streamer

- Drains the equalized image from output memory M4 (written by the output pipeline) and streams it out as 8-bit pixels over a valid/ready handshake.
- Sits on an M4 `sram_2R1W` read port, at the far end of the M4 write path.
- Once started, it fetches `word_count` consecutive 128-bit words from `base_addr` and serializes each word into 16 pixels.
- When the last pixel has been accepted, it pulses `done`.

## Interface
- `ADDR_W`, 16, M4 address width
- `DATA_W`, 128, M4 word width
- `PIX_W`, 8, pixel width; `DATA_W/PIX_W` (16) pixels per word
- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a transfer; sampled only while idle
- `base_addr`  in  ADDR_W  first M4 word address; captured on start
- `word_count`  in  ADDR_W  number of words to stream; captured on start
- `M4_ReadAddress`  out  ADDR_W  M4 read address; reset 0
- `M4_ReadBus`  in  DATA_W  M4 read data, valid one cycle after its address was driven
- `pix_data`  out  PIX_W  current pixel; reset 0
- `pix_valid`  out  1  pixel available; reset 0
- `pix_ready`  in  1  downstream accepts the pixel
- `busy`  out  1  transfer in progress; reset 0
- `done`  out  1  one-cycle pulse after the final handshake; reset 0
- `checksum`  out  16  pixel checksum (see Configuration); reset 0

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1 and `word_count`≠0.
  - IDLE → DONE when `start`=1 and `word_count`=0; no reads are issued.
  - RUN → DONE when the last pixel of the last word is handshaken.
  - DONE → IDLE unconditionally after one cycle; `done`=1 only in DONE.
- `busy`=1 in RUN; `start` is ignored while not IDLE.
- Read issue rule: issue a read when words remaining to issue > 0 and (FIFO occupancy + in-flight reads) < 2.
  - Issuing drives `M4_ReadAddress` with the next address, sets the in-flight flag and post-increments the address.
  - At most one read is in flight at a time.
- The cycle after an issue, `M4_ReadBus` is written into a 2-entry word FIFO.
- Serializer: a byte index (0..15) selects `pix_data` = FIFO head bits [8i+7:8i]. Byte 0 (bits [7:0]) is sent first.
  - `pix_valid` = FIFO non-empty.
  - A handshake (`pix_valid`&`pix_ready`) increments the index.
  - At index 15 the handshake pops the FIFO and resets the index to 0.
- `pix_data` and `pix_valid` stay stable while `pix_valid`=1 and `pix_ready`=0.
- Address arithmetic is modulo 2^ADDR_W: `base_addr`+n wraps past 0xFFFF to 0x0000.
- A push and a pop in the same cycle are legal; occupancy is unchanged.
- Reset mid-transfer returns to IDLE and clears the FIFO, the in-flight flag, the index and all outputs. `M4_ReadBus` data arriving the cycle after reset is discarded.

## Timing
- Start sampled at edge E0: `M4_ReadAddress`=base after E0; data captured at E2; `pix_valid`=1 after E2.
- First-pixel latency is therefore 2 cycles after the start edge.
- With `pix_ready` held high, throughput is 1 pixel/cycle with no bubbles between words. Refill needs 2 cycles against the 16 cycles it takes to drain a word.
- `done` rises the cycle after the final handshake.
- `busy` falls in the same cycle that `done` rises.
- A new `start` is accepted on the edge ending the cycle after `done`.

## Configuration
- `M4_READOUT_CHECKSUM_EN` defined:
  - A 16-bit accumulator clears on an accepted start and adds each handshaken pixel, zero-extended, modulo 2^16.
  - `checksum` holds the final sum from DONE until the next accepted start or reset.
- `M4_READOUT_CHECKSUM_EN` undefined: no accumulator is built and `checksum` is constant 0.

## Structure
- Shared package `hist_eq_pkg` holds:
  - the width constants `ADDR_W`, `DATA_W`, `PIX_W`, and the derived `PIX_PER_WORD`;
  - the FSM state enum `readout_state_t`.
- One sub-module: `word_fifo2`, the 2-entry DATA_W FIFO with push, pop, full, empty and head.
- The top level contains the FSM, read issue logic, serializer and checksum.

## Test plan
- Basic stream: M4[0x10..0x11] preloaded with bytes 0x00..0x1F, base=0x10, count=2, `pix_ready`=1.
  - Expect pixels 0x00..0x1F in order, `pix_valid` gap-free from 2 cycles after start.
  - Expect `done` 1 cycle after pixel 0x1F; checksum=0x01F0 with the macro defined.
- Backpressure: same data, `pix_ready` toggling 1-0-1-0 and held low for 20 cycles mid-word 0.
  - Expect no dropped or duplicated pixels, and `pix_data` stable while stalled.
  - Expect at most 2 reads issued before any pop.
- Zero count: start with count=0.
  - Expect `done` 1 cycle after the start edge, no address changes, and `pix_valid` never asserted.
- Wrap-around: base=0xFFFF, count=2.
  - Expect reads at 0xFFFF then 0x0000, with 32 pixels in that order.
- Reset mid-transfer: assert `reset` while pixel 5 of word 0 is pending.
  - Expect all outputs 0 the next cycle and the FIFO empty.
  - A subsequent start restreams correctly from the new base.
- Start while busy: pulse `start` with different base/count during RUN.
  - Expect the pulse to be ignored and the original transfer to complete unchanged.
